// File: rtl/apu_pkg.sv
// Shared types and constants for the APU audio capture unit register file.
// Register indices, CONTROL/STATUS layouts, event bit positions and a strobe helper.
package apu_pkg;

  typedef enum logic [4:0] {
    REG_STATUS         = 5'd0,
    REG_CONTROL        = 5'd1,
    REG_GAIN           = 5'd2,
    REG_DECIMATION     = 5'd3,
    REG_NORMALIZER     = 5'd4,
    REG_SAMPLE         = 5'd5,
    REG_EVENT          = 5'd6,
    REG_INT_ENABLE     = 5'd7,
    REG_WATERMARK      = 5'd8,
    REG_LEVEL          = 5'd9,
    REG_THRESHOLD_BASE = 5'd16
  } capture_unit_mc_registers_t;

  typedef struct packed {
    logic [14:0] reserved3;
    logic        all_channels;
    logic        reserved2;
    logic [2:0]  channel_select;
    logic        reserved1;
    logic        flush;
    logic        buffer_enable;
    logic        interface_enable;
    logic        reserved0;
    logic [6:0]  divisor;
  } capture_unit_mc_control_t;

  typedef struct packed {
    logic [28:0] reserved;
    logic        watermark;
    logic        full;
    logic        empty;
  } capture_unit_mc_status_t;

  localparam int EVT_FULL        = 0;
  localparam int EVT_WATERMARK   = 1;
  localparam int EVT_OVERRUN     = 2;
  localparam int EVT_INVALID     = 3;
  localparam int EVT_THRESH_BASE = 4;

  // Storable CONTROL bits; flush is deliberately excluded so it never reads back.
  localparam logic [31:0] CONTROL_WMASK = 32'h0001_737F;
  localparam logic [15:0] GAIN_RESET    = 16'h8000;

  function automatic logic [31:0] strobe_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{strb[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/capture_sample_fifo.sv
// First-word-fall-through sample FIFO with single-cycle flush and occupancy count.
// Head data is combinational from the array so a bus read sees it in the same cycle.
module capture_sample_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 512
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_COUNT);
  assign count_o = count_q;
  assign rdata_o = mem[rd_ptr_q];

  // A push into a full FIFO is fine when the head leaves on the same edge.
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ac_unit_registers_mc.sv
// Audio capture unit register file: configuration, tagged sample FIFO,
// per-channel threshold / watermark / overrun / invalid events and a maskable level interrupt.
module ac_unit_registers_mc
  import apu_pkg::*;
#(
  parameter int CHANNELS     = 2,
  parameter int SAMPLE_WIDTH = 16,
  parameter int BUFFER_SIZE  = 512
) (
  input  logic                                           clk_i,
  input  logic                                           rst_i,
  output logic                                           interrupt_o,
  input  logic [SAMPLE_WIDTH-1:0]                        pcm_sample_i,
  input  logic                                           valid_i,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] channel_i,
  input  logic                                           invalid_i,
  output logic [6:0]                                     divisor_o,
  output logic [7:0]                                     decimation_rate_o,
  output logic [15:0]                                    gain_o,
  output logic [31:0]                                    normalizer_o,
  output logic                                           enable_interface_o,
  output logic                                           all_channels_o,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] channel_select_o,
  input  logic                                           write_i,
  input  logic [4:0]                                     write_address_i,
  input  logic [31:0]                                    write_data_i,
  input  logic [3:0]                                     write_strobe_i,
  output logic                                           write_error_o,
  input  logic                                           read_i,
  input  logic [4:0]                                     read_address_i,
  output logic [31:0]                                    read_data_o,
  output logic                                           read_error_o
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int LW   = $clog2(BUFFER_SIZE) + 1;
  localparam int EW   = EVT_THRESH_BASE + 2 * CHANNELS;
  localparam int FW   = SAMPLE_WIDTH + 4;
  localparam logic [4:0]    THR_END    = 5'(REG_THRESHOLD_BASE + CHANNELS);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(BUFFER_SIZE);

  logic [31:0]   ctrl_q, ctrl_d;
  logic [15:0]   gain_q, gain_d;
  logic [7:0]    decim_q, decim_d;
  logic [31:0]   norm_q, norm_d;
  logic [EW-1:0] int_en_q, int_en_d, evt_q, evt_d, evt_raw, evt_clr;
  logic [LW-1:0] wm_q, wm_d;
  logic [31:0]   thr_q [CHANNELS];
  logic [31:0]   thr_d [CHANNELS];

  capture_unit_mc_control_t ctrl;
  capture_unit_mc_status_t  status;

  logic [31:0]   wmask;
  logic          wr_ok, wr_en, flush;
  logic          sample_rd, pop_req, push_cond, push_acc;
  logic          fifo_empty, fifo_full;
  logic [FW-1:0] fifo_rdata;
  logic [LW-1:0] fifo_count, level_next;
  logic [CHANNELS-1:0] hi_hit, lo_hit;

  assign ctrl  = capture_unit_mc_control_t'(ctrl_q);
  assign wmask = strobe_mask(write_strobe_i);

  always_comb begin
    wr_ok = 1'b0;
    case (write_address_i)
      REG_CONTROL, REG_GAIN, REG_DECIMATION, REG_NORMALIZER,
      REG_EVENT, REG_INT_ENABLE, REG_WATERMARK: wr_ok = 1'b1;
      default: wr_ok = (write_address_i >= REG_THRESHOLD_BASE) && (write_address_i < THR_END);
    endcase
  end

  assign write_error_o = write_i & ~wr_ok;
  assign wr_en         = write_i & wr_ok;
  assign flush = wr_en && (write_address_i == REG_CONTROL) && write_strobe_i[1] && write_data_i[10];

  assign sample_rd = read_i && (read_address_i == REG_SAMPLE);
  assign pop_req   = sample_rd & ~fifo_empty;
  assign push_cond = valid_i & ctrl.buffer_enable &
                     (ctrl.all_channels | (3'(channel_i) == ctrl.channel_select));
  assign push_acc  = push_cond & (~fifo_full | pop_req) & ~flush;

  capture_sample_fifo #(
    .WIDTH (FW),
    .DEPTH (BUFFER_SIZE)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_cond),
    .pop_i   (pop_req),
    .flush_i (flush),
    .wdata_i ({4'(channel_i), pcm_sample_i}),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Occupancy after this edge, so full/watermark events land with the push that causes them.
  always_comb begin
    level_next = fifo_count;
    if (flush)                    level_next = '0;
    else if (push_acc && !pop_req) level_next = fifo_count + 1'b1;
    else if (!push_acc && pop_req) level_next = fifo_count - 1'b1;
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    logic is_ch;
    always_comb begin
      thr_d[gi] = thr_q[gi];
      if (wr_en && (write_address_i == REG_THRESHOLD_BASE + 5'(gi)))
        thr_d[gi] = (thr_q[gi] & ~wmask) | (write_data_i & wmask);
    end
    assign is_ch      = push_acc && (3'(channel_i) == 3'(gi));
    assign hi_hit[gi] = is_ch && ($signed(pcm_sample_i) > $signed(thr_q[gi][16 +: SAMPLE_WIDTH]));
    assign lo_hit[gi] = is_ch && ($signed(pcm_sample_i) < $signed(thr_q[gi][0 +: SAMPLE_WIDTH]));
  end

  always_comb begin
    evt_raw = '0;
    evt_raw[EVT_FULL]      = (level_next == FULL_LEVEL) & ~fifo_full;
    evt_raw[EVT_WATERMARK] = (wm_q != '0) && (fifo_count < wm_q) && (level_next >= wm_q);
    evt_raw[EVT_OVERRUN]   = push_cond & fifo_full & ~pop_req;
    evt_raw[EVT_INVALID]   = invalid_i;
    for (int c = 0; c < CHANNELS; c++) begin
      evt_raw[EVT_THRESH_BASE + 2*c]     = hi_hit[c];
      evt_raw[EVT_THRESH_BASE + 2*c + 1] = lo_hit[c];
    end
  end

  always_comb begin
    ctrl_d   = ctrl_q;
    gain_d   = gain_q;
    decim_d  = decim_q;
    norm_d   = norm_q;
    int_en_d = int_en_q;
    wm_d     = wm_q;
    evt_clr  = '0;
    if (wr_en) begin
      case (write_address_i)
        REG_CONTROL:    ctrl_d   = ((ctrl_q & ~wmask) | (write_data_i & wmask)) & CONTROL_WMASK;
        REG_GAIN:       gain_d   = (gain_q & ~wmask[15:0]) | (write_data_i[15:0] & wmask[15:0]);
        REG_DECIMATION: decim_d  = (decim_q & ~wmask[7:0]) | (write_data_i[7:0] & wmask[7:0]);
        REG_NORMALIZER: norm_d   = (norm_q & ~wmask) | (write_data_i & wmask);
        REG_EVENT:      evt_clr  = write_data_i[EW-1:0] & wmask[EW-1:0];
        REG_INT_ENABLE: int_en_d = (int_en_q & ~wmask[EW-1:0]) | (write_data_i[EW-1:0] & wmask[EW-1:0]);
        REG_WATERMARK:  wm_d     = (wm_q & ~wmask[LW-1:0]) | (write_data_i[LW-1:0] & wmask[LW-1:0]);
        default: ;
      endcase
    end
    // Set after clear: a fresh event is never lost to a racing W1C write.
    evt_d = (evt_q & ~evt_clr) | (evt_raw & int_en_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q   <= '0;
      gain_q   <= GAIN_RESET;
      decim_q  <= '0;
      norm_q   <= '0;
      int_en_q <= '0;
      wm_q     <= '0;
      evt_q    <= '0;
      for (int c = 0; c < CHANNELS; c++) thr_q[c] <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      gain_q   <= gain_d;
      decim_q  <= decim_d;
      norm_q   <= norm_d;
      int_en_q <= int_en_d;
      wm_q     <= wm_d;
      evt_q    <= evt_d;
      thr_q    <= thr_d;
    end
  end

  always_comb begin
    status           = '0;
    status.empty     = fifo_empty;
    status.full      = fifo_full;
    status.watermark = (wm_q != '0) && (fifo_count >= wm_q);
  end

  always_comb begin
    read_data_o  = '0;
    read_error_o = 1'b0;
    if (read_i) begin
      case (read_address_i)
        REG_STATUS:     read_data_o = status;
        REG_CONTROL:    read_data_o = ctrl_q;
        REG_GAIN:       read_data_o = {16'b0, gain_q};
        REG_DECIMATION: read_data_o = {24'b0, decim_q};
        REG_NORMALIZER: read_data_o = norm_q;
        REG_SAMPLE: begin
          if (fifo_empty) read_error_o = 1'b1;
          else read_data_o = {12'b0, fifo_rdata[FW-1 -: 4],
                              16'($signed(fifo_rdata[SAMPLE_WIDTH-1:0]))};
        end
        REG_EVENT:      read_data_o = 32'(evt_q);
        REG_INT_ENABLE: read_data_o = 32'(int_en_q);
        REG_WATERMARK:  read_data_o = 32'(wm_q);
        REG_LEVEL:      read_data_o = 32'(fifo_count);
        default: begin
          if ((read_address_i >= REG_THRESHOLD_BASE) && (read_address_i < THR_END))
            read_data_o = thr_q[read_address_i[CH_W-1:0]];
          else
            read_error_o = 1'b1;
        end
      endcase
    end
  end

  assign interrupt_o        = |(evt_q & int_en_q);
  assign divisor_o          = ctrl.divisor;
  assign decimation_rate_o  = decim_q;
  assign gain_o             = gain_q;
  assign normalizer_o       = norm_q;
  assign enable_interface_o = ctrl.interface_enable;
  assign all_channels_o     = ctrl.all_channels;
  assign channel_select_o   = ctrl.channel_select[CH_W-1:0];

endmodule

// File: tb/tb_ac_unit_registers_mc.sv
// Directed bench for ac_unit_registers_mc with default parameters (2 channels, 16-bit, 512 deep).
module tb_ac_unit_registers_mc;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        interrupt_o;
  logic [15:0] pcm_sample_i = '0;
  logic        valid_i = 1'b0;
  logic [0:0]  channel_i = '0;
  logic        invalid_i = 1'b0;
  logic [6:0]  divisor_o;
  logic [7:0]  decimation_rate_o;
  logic [15:0] gain_o;
  logic [31:0] normalizer_o;
  logic        enable_interface_o;
  logic        all_channels_o;
  logic [0:0]  channel_select_o;
  logic        write_i = 1'b0;
  logic [4:0]  write_address_i = '0;
  logic [31:0] write_data_i = '0;
  logic [3:0]  write_strobe_i = '0;
  logic        write_error_o;
  logic        read_i = 1'b0;
  logic [4:0]  read_address_i = '0;
  logic [31:0] read_data_o;
  logic        read_error_o;

  int tests = 0;
  int fails = 0;
  logic [31:0] rd_data;
  logic        rd_err, wr_err;

  always #5 clk_i = ~clk_i;

  ac_unit_registers_mc dut (
    .clk_i(clk_i), .rst_i(rst_i), .interrupt_o(interrupt_o),
    .pcm_sample_i(pcm_sample_i), .valid_i(valid_i), .channel_i(channel_i),
    .invalid_i(invalid_i), .divisor_o(divisor_o), .decimation_rate_o(decimation_rate_o),
    .gain_o(gain_o), .normalizer_o(normalizer_o), .enable_interface_o(enable_interface_o),
    .all_channels_o(all_channels_o), .channel_select_o(channel_select_o),
    .write_i(write_i), .write_address_i(write_address_i), .write_data_i(write_data_i),
    .write_strobe_i(write_strobe_i), .write_error_o(write_error_o),
    .read_i(read_i), .read_address_i(read_address_i), .read_data_o(read_data_o),
    .read_error_o(read_error_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%08h", tag, got);
    end
  endtask

  // One clock with any mix of push / read / write; outputs captured before the edge.
  task automatic step(input logic do_push, input logic [0:0] ch, input logic [15:0] smp,
                      input logic do_rd, input logic [4:0] raddr,
                      input logic do_wr, input logic [4:0] waddr, input logic [31:0] wdata,
                      input logic [3:0] strb);
    valid_i = do_push; channel_i = ch; pcm_sample_i = smp;
    read_i = do_rd; read_address_i = raddr;
    write_i = do_wr; write_address_i = waddr; write_data_i = wdata; write_strobe_i = strb;
    #1;
    rd_data = read_data_o; rd_err = read_error_o; wr_err = write_error_o;
    @(posedge clk_i); #1;
    valid_i = 1'b0; read_i = 1'b0; write_i = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    step(1'b0, 1'b0, 16'h0, 1'b0, 5'd0, 1'b1, a, d, 4'hF);
  endtask

  task automatic push(input logic [0:0] ch, input logic [15:0] s);
    step(1'b1, ch, s, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 4'h0);
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    step(1'b0, 1'b0, 16'h0, 1'b1, a, 1'b0, 5'd0, 32'h0, 4'h0);
    check(tag, rd_data, exp);
  endtask

  logic [4:0]  rst_addr [11] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd7, 5'd8, 5'd9, 5'd16, 5'd17};
  logic [31:0] rst_exp  [11] = '{32'h1, 32'h0, 32'h8000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

  initial begin
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Reset state
    check("rst_irq", 32'(interrupt_o), 32'h0);
    for (int i = 0; i < 11; i++) rd_chk($sformatf("rst_reg%0d", rst_addr[i]), rst_addr[i], rst_exp[i]);
    rd_chk("rst_sample_data", 5'd5, 32'h0);
    check("rst_sample_err", 32'(rd_err), 32'h1);
    rd_chk("unmapped_rd_data", 5'd18, 32'h0);
    check("unmapped_rd_err", 32'(rd_err), 32'h1);

    // All-channels push and tagged sample reads
    wr(5'd1, 32'h0001_0200);
    rd_chk("ctrl_rb", 5'd1, 32'h0001_0200);
    push(1'b0, 16'h0010);
    push(1'b1, 16'hFFF0);
    rd_chk("level2", 5'd9, 32'd2);
    rd_chk("sample_ch0", 5'd5, 32'h0000_0010);
    rd_chk("sample_ch1", 5'd5, 32'h0001_FFF0);
    rd_chk("level0", 5'd9, 32'd0);

    // Watermark event, interrupt and W1C
    wr(5'd8, 32'd3);
    wr(5'd7, 32'h2);
    push(1'b0, 16'h0001);
    push(1'b0, 16'h0002);
    rd_chk("wm_evt_before", 5'd6, 32'h0);
    push(1'b0, 16'h0003);
    check("wm_irq_set", 32'(interrupt_o), 32'h1);
    rd_chk("wm_evt", 5'd6, 32'h2);
    rd_chk("wm_status", 5'd0, 32'h4);
    wr(5'd6, 32'h2);
    check("wm_irq_clr", 32'(interrupt_o), 32'h0);
    wr(5'd1, 32'h0001_0600);
    rd_chk("flush_level", 5'd9, 32'd0);
    rd_chk("flush_ctrl_rb", 5'd1, 32'h0001_0200);

    // Fill, overrun, push+pop while full
    wr(5'd7, 32'h7);
    wr(5'd6, 32'hFFFF_FFFF);
    for (int i = 0; i < 512; i++) push(1'b0, 16'(i + 1));
    rd_chk("fill_evt", 5'd6, 32'h3);
    rd_chk("fill_level", 5'd9, 32'd512);
    rd_chk("fill_status", 5'd0, 32'h6);
    push(1'b0, 16'h7777);
    rd_chk("overrun_evt", 5'd6, 32'h7);
    rd_chk("overrun_level", 5'd9, 32'd512);
    wr(5'd6, 32'h7);
    step(1'b1, 1'b0, 16'hABCD, 1'b1, 5'd5, 1'b0, 5'd0, 32'h0, 4'h0);
    check("full_pushpop_data", rd_data, 32'h0000_0001);
    check("full_pushpop_err", 32'(rd_err), 32'h0);
    rd_chk("full_pushpop_level", 5'd9, 32'd512);
    rd_chk("full_pushpop_evt", 5'd6, 32'h0);
    rd_chk("full_next_head", 5'd5, 32'h0000_0002);
    wr(5'd1, 32'h0001_0600);
    rd_chk("flush_status", 5'd0, 32'h1);

    // Per-channel thresholds
    wr(5'd8, 32'd0);
    wr(5'd7, 32'hFF);
    wr(5'd6, 32'hFF);
    wr(5'd17, 32'h1000_F000);
    rd_chk("thr1_rb", 5'd17, 32'h1000_F000);
    push(1'b1, 16'h1000);
    rd_chk("thr_equal", 5'd6, 32'h0);
    push(1'b1, 16'h1001);
    rd_chk("thr_high", 5'd6, 32'h40);
    push(1'b1, 16'hEFFF);
    rd_chk("thr_low", 5'd6, 32'hC0);
    wr(5'd6, 32'hFF);
    push(1'b0, 16'h7FFF);
    push(1'b0, 16'h8000);
    rd_chk("thr_ch0_only", 5'd6, 32'h30);
    check("thr_irq", 32'(interrupt_o), 32'h1);
    wr(5'd7, 32'h0);
    check("masked_irq", 32'(interrupt_o), 32'h0);
    rd_chk("masked_evt_kept", 5'd6, 32'h30);

    // Flush beats same-cycle push and pop
    step(1'b1, 1'b0, 16'h1234, 1'b1, 5'd5, 1'b1, 5'd1, 32'h0001_0600, 4'hF);
    check("flushpp_head", rd_data, 32'h0001_1000);
    check("flushpp_wr_err", 32'(wr_err), 32'h0);
    rd_chk("flushpp_level", 5'd9, 32'd0);
    rd_chk("flushpp_status", 5'd0, 32'h1);

    // Write errors and byte strobes
    wr(5'd0, 32'hFFFF_FFFF);
    check("wr_status_err", 32'(wr_err), 32'h1);
    rd_chk("wr_status_nochg", 5'd0, 32'h1);
    rd_chk("wr_status_ctrl", 5'd1, 32'h0001_0200);
    wr(5'd12, 32'h1);
    check("wr_unmapped_err", 32'(wr_err), 32'h1);
    wr(5'd16, 32'h7FFF_8000);
    check("wr_thr0_err", 32'(wr_err), 32'h0);
    rd_chk("thr0_rb", 5'd16, 32'h7FFF_8000);
    step(1'b0, 1'b0, 16'h0, 1'b0, 5'd0, 1'b1, 5'd2, 32'h1234_5678, 4'b0001);
    rd_chk("gain_strobe", 5'd2, 32'h0000_8078);
    check("gain_o", 32'(gain_o), 32'h8078);
    wr(5'd3, 32'h0000_00AB);
    check("decim_o", 32'(decimation_rate_o), 32'hAB);
    wr(5'd4, 32'hDEAD_BEEF);
    check("norm_o", normalizer_o, 32'hDEAD_BEEF);

    // Selected-channel mode
    wr(5'd1, 32'h0000_1355);
    check("divisor_o", 32'(divisor_o), 32'h55);
    check("if_en_o", 32'(enable_interface_o), 32'h1);
    check("ch_sel_o", 32'(channel_select_o), 32'h1);
    check("all_ch_o", 32'(all_channels_o), 32'h0);
    push(1'b0, 16'h0005);
    push(1'b1, 16'h0006);
    rd_chk("sel_level", 5'd9, 32'd1);
    rd_chk("sel_sample", 5'd5, 32'h0001_0006);

    // Reset mid-operation
    push(1'b1, 16'h0007);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    rd_chk("midrst_level", 5'd9, 32'd0);
    rd_chk("midrst_gain", 5'd2, 32'h8000);
    rd_chk("midrst_ctrl", 5'd1, 32'h0);
    check("midrst_irq", 32'(interrupt_o), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ac_unit_registers_mc.md
Name: ac_unit_registers_mc

Overview:
Multi-channel, parametrised register file for the APU audio capture unit. It holds capture configuration (clock divisor, gain, decimation, normalizer, channel mode) and buffers tagged PCM samples in a first-word-fall-through FIFO with an occupancy counter. It detects per-channel high/low threshold crossings, watermark, overrun and invalid-frame events, and raises a level-sensitive, maskable, write-1-to-clear interrupt. It sits between the bus slave adapter and the capture datapath (PDM/decimator/gain chain).

Parameters:
CHANNELS, 2, number of capture channels; legal range 1..8.
SAMPLE_WIDTH, 16, PCM sample width in bits; legal range 8..16; samples are signed two's complement.
BUFFER_SIZE, 512, FIFO depth in samples; power of two, at least 4.

Ports:
clk_i  in  1  system clock; the only clock.
rst_i  in  1  synchronous, active-high reset.
interrupt_o  out  1  level interrupt: OR of (event_register & int_enable_register).
pcm_sample_i  in  SAMPLE_WIDTH  signed sample from the datapath.
valid_i  in  1  pcm_sample_i and channel_i are valid this cycle.
channel_i  in  $clog2(CHANNELS) (minimum 1)  channel index of the sample.
invalid_i  in  1  datapath reports a corrupted or dropped frame.
divisor_o  out  7  clock divisor.
decimation_rate_o  out  8  decimation factor.
gain_o  out  16  gain in Q1.15 format.
normalizer_o  out  32  normalizer value.
enable_interface_o  out  1  microphone interface enable.
all_channels_o  out  1  1 = capture all channels; 0 = capture the selected channel only.
channel_select_o  out  $clog2(CHANNELS) (minimum 1)  selected channel.
write_i, write_address_i[4:0], write_data_i[31:0], write_strobe_i[3:0]  in  bus write; write_error_o  out  1.
read_i, read_address_i[4:0]  in  bus read; read_data_o  out  32; read_error_o  out  1.

Behaviour:
- Register map (word index): 0 STATUS (RO), 1 CONTROL, 2 GAIN, 3 DECIMATION, 4 NORMALIZER, 5 SAMPLE (RO, read pops), 6 EVENT (W1C), 7 INT_ENABLE, 8 WATERMARK, 9 LEVEL (RO), 16+c THRESHOLD[c] for c < CHANNELS. All other indices are unmapped.
- CONTROL bit layout:
  - [6:0] divisor
  - [8] interface enable
  - [9] buffer enable
  - [10] flush (write-only, self-clearing, always reads 0)
  - [14:12] channel select
  - [16] all-channels mode
  - Byte strobes apply per byte, as in every register.
- THRESHOLD[c]: [15:0] low threshold, [31:16] high threshold. Sign-extended from SAMPLE_WIDTH; comparisons are signed.
- Reset values:
  - all registers 0, except GAIN = 16'h8000
  - FIFO empty, LEVEL = 0
  - interrupt_o = 0, write_error_o = 0, read_error_o = 0
- Reads are combinational in the same cycle. A SAMPLE read returns {channel tag in [19:16], sample sign-extended into [15:0]} from the FIFO head and pops on that clock edge.
- Push condition: valid_i & buffer enable & (all-channels mode | channel_i == channel select) & !full.
- Simultaneous push and pop: both occur and LEVEL is unchanged. A push while full but with a same-cycle pop is accepted.
- Flush: empties the FIFO in one cycle and has priority over a same-cycle push or pop; neither of those takes effect.
- SAMPLE read while empty: read_data_o = 0, read_error_o = 1, no pointer change.
- Error flags (combinational, no state change):
  - write_error_o: write_i to STATUS, SAMPLE, LEVEL or an unmapped index.
  - read_error_o: read_i to an unmapped index (read_data_o = 0), or an empty SAMPLE read as above.
- Event bits, each set on the cycle after its condition, gated by the matching INT_ENABLE bit:
  - 0 full: rising edge of full.
  - 1 watermark: LEVEL goes from below WATERMARK to at or above it; WATERMARK = 0 disables this event.
  - 2 overrun: push condition blocked by full with no same-cycle pop.
  - 3 invalid: invalid_i.
  - 4+2c: accepted sample of channel c is strictly greater than high[c].
  - 5+2c: accepted sample of channel c is strictly less than low[c].
  - Unused upper bits read 0.
- EVENT write: each written 1 clears that bit. If a set and a clear hit the same bit in the same cycle, the set wins.
- interrupt_o: combinational from registered state. It stays asserted until software clears the bit or masks it.
- STATUS: [0] empty, [1] full, [2] watermark reached (LEVEL >= WATERMARK with WATERMARK nonzero).
- LEVEL: occupancy, 0..BUFFER_SIZE.
- Reset asserted mid-operation: the FIFO is discarded and all state returns to reset values on the next edge.

Decomposition:
- apu_pkg:
  - capture_unit_mc_registers_t enum (indices 0..9 and THRESHOLD_BASE = 16)
  - capture_unit_mc_control_t and capture_unit_mc_status_t packed structs
  - event bit index constants (EVT_FULL, EVT_WATERMARK, EVT_OVERRUN, EVT_INVALID, EVT_THRESH_BASE)
- Sub-module capture_sample_fifo: first-word-fall-through FIFO with flush and a count output; width SAMPLE_WIDTH + 4, depth BUFFER_SIZE.

Test Plan:
- Reset, then read every register -> GAIN = 32'h00008000, all others 0, STATUS = 32'h1, interrupt_o = 0; SAMPLE read gives 0 with read_error_o = 1.
- CHANNELS = 2, all-channels mode, push ch0 = 16'h0010 then ch1 = 16'hFFF0 -> LEVEL = 2; SAMPLE reads give 32'h00000010 then 32'h0001FFF0; LEVEL = 0.
- WATERMARK = 3, INT_ENABLE bit1 = 1, push 3 samples -> EVENT bit1 set one cycle after the third push, interrupt_o = 1; W1C write of 32'h2 -> interrupt_o = 0 next cycle.
- Fill BUFFER_SIZE samples, then one more push -> full and overrun events; LEVEL stays at BUFFER_SIZE. Push plus SAMPLE read in the same cycle while full -> accepted, LEVEL unchanged.
- THRESHOLD[1] = {16'h1000, 16'hF000}; ch1 samples 16'h1001, 16'hEFFF, 16'h1000 -> EVENT bits 6 and 7 set; 16'h1000 sets nothing; ch0 samples never set bits 6 or 7.
- Flush during a simultaneous push and pop -> LEVEL = 0 and empty = 1 the next cycle; a write to STATUS -> write_error_o = 1 and no state change.
